// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender between fetch and execute.
// Decodes the instruction format from the opcode, sign-extends the immediate
// to XLEN, flags unsupported opcodes and optionally computes pc+imm. Two
// entries of storage (output register + skid entry) keep FIFO order.
//
// Handshake: an input is accepted on a rising clk when in_valid & in_ready
// and flush is low; an output transfers on a rising clk when out_valid &
// out_ready and flush is low. in_ready is a pure function of state (skid
// entry empty) and never depends combinationally on out_ready. While
// out_valid=1 and out_ready=0 the out_* fields are held stable.
`timescale 1ns/1ps
module imm_ext_pipe #(
    parameter int XLEN      = 32,
    parameter bit TARGET_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target,
    output logic [1:0]      dbg_state_o
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    // EMPTY: nothing held; ONE: output register valid; FULL: skid also valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] target;
    } entry_t;

    state_t state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t dec;

    logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32, imm_z32;
    logic [31:0] imm32;
    logic        target_sel;

    // Widen a 32-bit sign-extended immediate to XLEN (no-op when XLEN=32).
    function automatic logic [XLEN-1:0] widen(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // Candidate immediates for every format, each already sign-extended to 32 bits.
    always_comb begin
        imm_i32 = {{20{in_instr[31]}}, in_instr[31:20]};
        imm_s32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        imm_b32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        imm_u32 = {in_instr[31:12], 12'h000};
        imm_j32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        imm_z32 = {27'd0, in_instr[19:15]};
    end

    // Opcode decode into a complete entry; only B, J and AUIPC produce a target.
    always_comb begin
        dec        = '0;
        imm32      = '0;
        target_sel = 1'b0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec.fmt = FMT_I;
                imm32   = imm_i32;
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec.fmt = FMT_I;
                    imm32   = imm_i32;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = imm_s32;
            end
            7'b1100011: begin
                dec.fmt    = FMT_B;
                imm32      = imm_b32;
                target_sel = 1'b1;
            end
            7'b0110111: begin
                dec.fmt = FMT_U;
                imm32   = imm_u32;
            end
            7'b0010111: begin
                dec.fmt    = FMT_U;
                imm32      = imm_u32;
                target_sel = 1'b1;
            end
            7'b1101111: begin
                dec.fmt    = FMT_J;
                imm32      = imm_j32;
                target_sel = 1'b1;
            end
            7'b1110011: begin
                // funct3[2] selects the CSR immediate forms (zimm in rs1 field).
                if (in_instr[14]) begin
                    dec.fmt = FMT_Z;
                    imm32   = imm_z32;
                end else begin
                    dec.fmt = FMT_I;
                    imm32   = imm_i32;
                end
            end
            default: begin
                dec.fmt     = FMT_NONE;
                dec.illegal = 1'b1;
            end
        endcase
        dec.imm = widen(imm32);
        if (TARGET_EN && target_sel) begin
            dec.target = in_pc + dec.imm;
        end
    end

    // Next-state and storage update; flush wins over accept and transfer.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        out_d   = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({in_valid, out_ready})
                        2'b11: out_d = dec;
                        2'b10: begin
                            skid_d  = dec;
                            state_d = ST_FULL;
                        end
                        2'b01: state_d = ST_EMPTY;
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid entry can move.
                    if (out_ready) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and storage registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        in_ready    = (state_q != ST_FULL);
        out_valid   = (state_q != ST_EMPTY);
        out_imm     = out_q.imm;
        out_fmt     = out_q.fmt;
        out_illegal = out_q.illegal;
        out_target  = out_q.target;
        dbg_state_o = state_q;
    end

endmodule
